fa_bist_ctrl: RTL and testbench

FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

---
 rtl/fa_bist_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fa_bist_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_bist_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fa_bist_ctrl
// Built-in self-test sequencer for a single-bit full adder. A run applies the
// eight input vectors {a,b,cin} = 0..7 in order. Each vector is held for
// SETTLE cycles and the adder outputs are then compared against the ideal
// full-adder response for one cycle. Mismatches are counted and reported as
// they happen, and a pass/fail verdict is published at the end of the run.
//
// Parameters
//   SETTLE          cycles between applying a vector and sampling (1..15)
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous, active-high reset
//   start           request a run; honoured only when idle or finishing
//   dut_sum         sum output of the adder under test
//   dut_cout        carry output of the adder under test
//   tst_a/b/cin     registered stimulus; 000 whenever no run is active
//   busy            high while vectors are being applied and checked
//   done            one-cycle pulse following the last busy cycle
//   pass            verdict of the last completed run (1 = clean)
//   fail_cnt        mismatched vectors in the current/last run (0..8)
//   first_fail_vec  index of the first mismatched vector of the run
//   err_valid       one-cycle pulse per mismatch
//   err_vec         index of the mismatched vector while err_valid is high
// ---------------------------------------------------------------------------
module fa_bist_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       tst_a,
    output logic       tst_b,
    output logic       tst_cin,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [2:0] first_fail_vec,
    output logic       err_valid,
    output logic [2:0] err_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Terminal count of the settle counter; the counter starts at 0 on
    // entry to WAIT, so WAIT lasts exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;
    logic       err_valid_q, err_valid_d;
    logic [2:0] err_vec_q, err_vec_d;

    logic       start_run;
    logic       exp_sum;
    logic       exp_cout;
    logic       mismatch;
    logic [3:0] fail_cnt_nxt;

    // Ideal full-adder response for the vector currently applied.
    always_comb begin
        exp_sum  = vec_q[2] ^ vec_q[1] ^ vec_q[0];
        exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) |
                   (vec_q[1] & vec_q[0]);
    end

    always_comb begin
        start_run    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        mismatch     = (state_q == S_CHECK) &&
                       ((dut_sum != exp_sum) || (dut_cout != exp_cout));
        fail_cnt_nxt = mismatch ? (fail_cnt_q + 4'd1) : fail_cnt_q;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
            S_CHECK: state_d = (vec_q == 3'd7) ? S_DONE : S_WAIT;
            S_DONE:  state_d = start ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        err_valid_d  = mismatch;
        err_vec_d    = mismatch ? vec_q : 3'd0;

        if (start_run) begin
            // Fresh run: vector 0 goes out on the same edge as the state
            // change, and results of the previous run are discarded.
            vec_d        = 3'd0;
            cnt_d        = 4'd0;
            fail_cnt_d   = 4'd0;
            first_fail_d = 3'd0;
            pass_d       = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_d = cnt_q + 4'd1;
                end
                S_CHECK: begin
                    fail_cnt_d = fail_cnt_nxt;
                    if (mismatch && (fail_cnt_q == 4'd0)) begin
                        first_fail_d = vec_q;
                    end
                    cnt_d = 4'd0;
                    if (vec_q == 3'd7) begin
                        // Stimulus returns to 000 for DONE; the verdict
                        // already includes the last vector's result.
                        vec_d  = 3'd0;
                        pass_d = (fail_cnt_nxt == 4'd0);
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
                default: begin
                    vec_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= 3'd0;
            cnt_q        <= 4'd0;
            fail_cnt_q   <= 4'd0;
            first_fail_q <= 3'd0;
            pass_q       <= 1'b0;
            err_valid_q  <= 1'b0;
            err_vec_q    <= 3'd0;
        end else begin
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            err_valid_q  <= err_valid_d;
            err_vec_q    <= err_vec_d;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy = (state_q == S_WAIT) || (state_q == S_CHECK);
        done = (state_q == S_DONE);
    end

    assign tst_a          = vec_q[2];
    assign tst_b          = vec_q[1];
    assign tst_cin        = vec_q[0];
    assign pass           = pass_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vec = first_fail_q;
    assign err_valid      = err_valid_q;
    assign err_vec        = err_vec_q;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
`timescale 1ns/1ps
module tb_fa_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Unit A uses the default SETTLE (1), unit B uses SETTLE=3.
    logic st_a = 1'b0, st_b = 1'b0;
    logic sum_a, cout_a, sum_b, cout_b;
    logic a_ta, a_tb, a_tc, a_busy, a_done, a_pass, a_ev;
    logic b_ta, b_tb, b_tc, b_busy, b_done, b_pass, b_ev;
    logic [3:0] a_fc, b_fc;
    logic [2:0] a_ff, b_ff, a_evec, b_evec;

    fa_bist_ctrl u_a (
        .clk(clk), .rst(rst), .start(st_a), .dut_sum(sum_a), .dut_cout(cout_a),
        .tst_a(a_ta), .tst_b(a_tb), .tst_cin(a_tc), .busy(a_busy), .done(a_done),
        .pass(a_pass), .fail_cnt(a_fc), .first_fail_vec(a_ff),
        .err_valid(a_ev), .err_vec(a_evec)
    );

    fa_bist_ctrl #(.SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(st_b), .dut_sum(sum_b), .dut_cout(cout_b),
        .tst_a(b_ta), .tst_b(b_tb), .tst_cin(b_tc), .busy(b_busy), .done(b_done),
        .pass(b_pass), .fail_cnt(b_fc), .first_fail_vec(b_ff),
        .err_valid(b_ev), .err_vec(b_evec)
    );

    // ---------------- adder-under-test models ----------------
    // mode 0: ideal adder with per-vector fault masks, 1: cout stuck at 0,
    // 2: ideal adder seen through a two-cycle delay.
    int         mode_a = 0, mode_b = 0;
    logic [7:0] sum_mask = '0, cout_mask = '0;
    logic [2:0] va, vb, da1, da2, db1, db2;

    assign va = {a_ta, a_tb, a_tc};
    assign vb = {b_ta, b_tb, b_tc};

    always @(posedge clk) begin
        da1 <= va; da2 <= da1;
        db1 <= vb; db2 <= db1;
    end

    function automatic logic [1:0] fa_ref(input logic [2:0] v);
        int s;
        s = int'(v[2]) + int'(v[1]) + int'(v[0]);
        return {s >= 2, s % 2 == 1};
    endfunction

    function automatic logic [1:0] adder(input int mode, input logic [2:0] v,
                                         input logic [2:0] vd, input logic [7:0] sm,
                                         input logic [7:0] cm);
        logic [1:0] r;
        case (mode)
            1:       begin r = fa_ref(v); r[1] = 1'b0; end
            2:       r = fa_ref(vd);
            default: begin r = fa_ref(v); r[1] = r[1] ^ cm[v]; r[0] = r[0] ^ sm[v]; end
        endcase
        return r;
    endfunction

    always_comb begin
        {cout_a, sum_a} = adder(mode_a, va, da2, sum_mask, cout_mask);
        {cout_b, sum_b} = adder(mode_b, vb, db2, sum_mask, cout_mask);
    end

    // ---------------- observation mux ----------------
    int         cur = 0;
    logic [2:0] o_vec, o_ff, o_evec;
    logic       o_busy, o_done, o_pass, o_ev;
    logic [3:0] o_fc;
    logic [14:0] all_a, all_b;

    always_comb begin
        if (cur == 0) begin
            o_vec = va; o_busy = a_busy; o_done = a_done; o_pass = a_pass;
            o_fc = a_fc; o_ff = a_ff; o_ev = a_ev; o_evec = a_evec;
        end else begin
            o_vec = vb; o_busy = b_busy; o_done = b_done; o_pass = b_pass;
            o_fc = b_fc; o_ff = b_ff; o_ev = b_ev; o_evec = b_evec;
        end
    end

    assign all_a = {va, a_busy, a_done, a_pass, a_fc, a_ff, a_ev, a_evec};
    assign all_b = {vb, b_busy, b_done, b_pass, b_fc, b_ff, b_ev, b_evec};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) st_a = v; else st_b = v;
    endtask

    // One complete run. Expectations come from exp_mask (set of vectors that
    // must be reported) and exp_pass; per-cycle stimulus order is derived
    // from the settle time.
    task automatic do_run(input string tag, input int sel, input int settle,
                          input bit already, input bit hold, input bit noise,
                          input bit chk_mask, input logic [7:0] exp_mask,
                          input logic exp_pass);
        int         busy_cnt, order_err, pulses, exp_cnt, exp_first;
        logic [7:0] seen;
        bit         got_done;
        busy_cnt = 0; order_err = 0; pulses = 0; seen = '0; got_done = 0;
        exp_cnt = 0; exp_first = -1;
        for (int i = 0; i < 8; i++) begin
            if (exp_mask[i]) begin
                exp_cnt++;
                if (exp_first < 0) exp_first = i;
            end
        end
        if (exp_first < 0) exp_first = 0;
        cur = sel;
        if (!already) begin
            @(negedge clk);
            set_start(sel, 1'b1);
        end
        @(negedge clk);
        if (!hold) set_start(sel, 1'b0);
        chk({tag, ".busy_first"}, 32'(o_busy), 32'd1);
        chk({tag, ".cleared_cnt"}, 32'(o_fc), 32'(o_ev ? 1 : 0) == 32'd1 ? 32'(o_fc) : 32'd0);
        chk({tag, ".cleared_pass"}, 32'(o_pass), 32'd0);
        for (int c = 0; c < 400; c++) begin
            if (o_busy) begin
                if (int'(o_vec) != busy_cnt / (settle + 1)) order_err++;
                busy_cnt++;
            end
            if (o_ev) begin
                seen[o_evec] = 1'b1;
                pulses++;
            end
            if (o_done) begin
                got_done = 1;
                set_start(sel, hold);
                break;
            end
            if (noise && o_busy) set_start(sel, 1'($urandom_range(0, 1)));
            @(negedge clk);
        end
        chk({tag, ".done_seen"}, 32'(got_done), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(8 * (settle + 1)));
        chk({tag, ".vec_order"}, 32'(order_err), 32'd0);
        chk({tag, ".done_busy"}, 32'(o_busy), 32'd0);
        chk({tag, ".done_stim"}, 32'(o_vec), 32'd0);
        chk({tag, ".pass"}, 32'(o_pass), 32'(exp_pass));
        if (chk_mask) begin
            chk({tag, ".err_set"}, 32'(seen), 32'(exp_mask));
            chk({tag, ".err_pulses"}, 32'(pulses), 32'(exp_cnt));
            chk({tag, ".fail_cnt"}, 32'(o_fc), 32'(exp_cnt));
            chk({tag, ".first_fail"}, 32'(o_ff), 32'(exp_first));
        end
        if (!hold) begin
            @(negedge clk);
            chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
            chk({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
            chk({tag, ".pass_hold"}, 32'(o_pass), 32'(exp_pass));
            if (chk_mask) chk({tag, ".cnt_hold"}, 32'(o_fc), 32'(exp_cnt));
        end
    endtask

    initial begin
        logic [7:0] m;
        bit         found;
        int         sel;

        // Reset state, with start asserted to confirm reset dominates.
        st_a = 1'b1; st_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.all_a", 32'(all_a), 32'd0);
        chk("reset.all_b", 32'(all_b), 32'd0);
        st_a = 1'b0; st_b = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.idle_a", 32'(a_busy), 32'd0);

        // Clean adder, default settle.
        mode_a = 0; sum_mask = '0; cout_mask = '0;
        do_run("clean_s1", 0, 1, 0, 0, 0, 1, 8'h00, 1'b1);

        // Carry stuck at 0: vectors 3,5,6,7 must be flagged.
        mode_a = 1;
        do_run("cout_sa0", 0, 1, 0, 0, 0, 1, 8'hE8, 1'b0);

        // Sum inverted on every vector.
        mode_a = 0; sum_mask = 8'hFF;
        do_run("sum_inv", 0, 1, 0, 0, 0, 1, 8'hFF, 1'b0);
        sum_mask = '0;

        // Reset in the middle of a run, while vector 4 is applied.
        cur = 0;
        @(negedge clk); st_a = 1'b1;
        @(negedge clk); st_a = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (a_busy && va == 3'd4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst.reach_v4", 32'(found), 32'd1);
        rst = 1'b1; st_a = 1'b1;
        @(negedge clk);
        chk("midrst.all_zero", 32'(all_a), 32'd0);
        rst = 1'b0; st_a = 1'b0;
        @(negedge clk);
        chk("midrst.stay_idle", 32'(a_busy), 32'd0);
        do_run("after_rst", 0, 1, 0, 0, 0, 1, 8'h00, 1'b1);

        // Start held high across a whole run, then an immediate restart
        // with a different fault pattern.
        do_run("hold_run1", 0, 1, 0, 1, 0, 1, 8'h00, 1'b1);
        sum_mask = 8'h24;
        do_run("hold_run2", 0, 1, 1, 0, 0, 1, 8'h24, 1'b0);
        sum_mask = '0;

        // Two-cycle-late adder: fine with SETTLE=3, caught with SETTLE=1.
        mode_b = 2;
        do_run("late_s3", 1, 3, 0, 0, 0, 1, 8'h00, 1'b1);
        mode_a = 2;
        do_run("late_s1", 0, 1, 0, 0, 0, 0, 8'h00, 1'b0);
        mode_a = 0; mode_b = 0;

        // Random fault patterns with spurious start pulses during the run.
        for (int r = 0; r < 8; r++) begin
            sel = int'($urandom_range(0, 1));
            sum_mask = 8'($urandom);
            cout_mask = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                sum_mask = '0; cout_mask = '0;
            end
            m = sum_mask | cout_mask;
            do_run($sformatf("rand%0d", r), sel, (sel == 0) ? 1 : 3, 0, 0, 1, 1,
                   m, m == 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
